// File: rtl/mult_div_unit.sv
`default_nettype none
//==============================================================================
//  Module   : mult_div_unit
//  Purpose  : Iterative multiply/divide unit that feeds the HI/LO registers of
//             the multicycle CPU. Executes mult, multu, div and divu by
//             shift-add multiplication and restoring division, resolving one
//             bit per clock.
//
//  Ports    : clk       - system clock, rising edge active
//             reset     - asynchronous, active-high reset
//             start     - operation request, sampled only while idle
//             op        - 00 mult, 01 multu, 10 div, 11 divu
//             a         - multiplicand / dividend
//             b         - multiplier / divisor
//             busy      - operation in progress
//             done      - one-cycle completion pulse
//             div_zero  - one-cycle pulse with done when the divisor is zero
//             hi        - product high half, or remainder
//             lo        - product low half, or quotient
//
//  Revision : 1.0 - initial parametrised release
//==============================================================================
module mult_div_unit #(
   parameter int WIDTH = 32,   // operand width, 4..64
   parameter int CNT_W = 6     // iteration counter width, 2**CNT_W > WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   // The counter runs 0..WIDTH-1 for the iterations; reaching WIDTH marks the
   // writeback edge where signs are applied and HI/LO are loaded.
   localparam logic [CNT_W-1:0] c_lastCnt = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] c_cntOne  = CNT_W'(1);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_isDiv;   // latched op[1]
   logic             r_negQ;    // negate product / quotient at writeback
   logic             r_negR;    // negate remainder (dividend was negative)
   logic             r_dz;      // divide by zero detected at start
   logic [WIDTH-1:0] r_acc;     // product high half / partial remainder
   logic [WIDTH-1:0] r_mplr;    // multiplier shifting out / quotient shifting in
   logic [WIDTH-1:0] r_opnd;    // multiplicand magnitude / divisor magnitude

   //---------------------------------------------------------------------------
   // Operand decode at the start edge: the core only ever sees magnitudes.
   // |-2^(W-1)| = 2^(W-1) still fits because the core is unsigned.
   //---------------------------------------------------------------------------
   logic             w_signed;
   logic             w_aNeg;
   logic             w_bNeg;
   logic [WIDTH-1:0] w_magA;
   logic [WIDTH-1:0] w_magB;

   assign w_signed = ~op[0];
   assign w_aNeg   = w_signed & a[WIDTH-1];
   assign w_bNeg   = w_signed & b[WIDTH-1];
   assign w_magA   = w_aNeg ? -a : a;
   assign w_magB   = w_bNeg ? -b : b;

   //---------------------------------------------------------------------------
   // Multiply step: add the multiplicand when the current multiplier LSB is
   // set, then shift {acc,mplr} right by one. The carry out of the add becomes
   // the new MSB of acc, so no product bit is lost.
   //---------------------------------------------------------------------------
   logic [WIDTH:0] w_sum;

   assign w_sum = {1'b0, r_acc} + (r_mplr[0] ? {1'b0, r_opnd} : '0);

   //---------------------------------------------------------------------------
   // Restoring divide step: shift the next dividend bit into the remainder and
   // subtract the divisor if it fits. The remainder stays below the divisor,
   // so the shifted value needs only one extra bit and the difference always
   // fits back into WIDTH bits.
   //---------------------------------------------------------------------------
   logic [WIDTH:0]   w_shift;
   logic             w_fits;
   logic [WIDTH-1:0] w_remNext;
   logic [WIDTH-1:0] w_quoNext;

   assign w_shift   = {r_acc, r_mplr[WIDTH-1]};
   assign w_fits    = (w_shift >= {1'b0, r_opnd});
   assign w_remNext = w_fits ? (w_shift[WIDTH-1:0] - r_opnd) : w_shift[WIDTH-1:0];
   assign w_quoNext = {r_mplr[WIDTH-2:0], w_fits};

   //---------------------------------------------------------------------------
   // Writeback sign correction. The quotient follows the XOR of operand signs
   // and the remainder follows the dividend, which gives truncation toward
   // zero. For -2^(W-1) / -1 the quotient magnitude 2^(W-1) is reused as-is,
   // which is the wrapped two's-complement result.
   //---------------------------------------------------------------------------
   logic [2*WIDTH-1:0] w_prod;
   logic [2*WIDTH-1:0] w_prodRes;
   logic [WIDTH-1:0]   w_quoRes;
   logic [WIDTH-1:0]   w_remRes;

   assign w_prod    = {r_acc, r_mplr};
   assign w_prodRes = r_negQ ? -w_prod : w_prod;
   assign w_quoRes  = r_negQ ? -r_mplr : r_mplr;
   assign w_remRes  = r_negR ? -r_acc  : r_acc;

   //---------------------------------------------------------------------------
   // Control and datapath registers.
   // The accept edge moves to RUN without raising busy; busy rises on the
   // first RUN edge and stays up through the FIN (done) cycle, giving a busy
   // window of WIDTH+1 cycles. A zero divisor skips the iterations and takes
   // the writeback path on the first RUN edge, leaving HI/LO untouched.
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_isDiv  <= 1'b0;
         r_negQ   <= 1'b0;
         r_negR   <= 1'b0;
         r_dz     <= 1'b0;
         r_acc    <= '0;
         r_mplr   <= '0;
         r_opnd   <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               busy     <= 1'b0;
               done     <= 1'b0;
               div_zero <= 1'b0;
               if (start) begin
                  r_isDiv <= op[1];
                  r_negQ  <= w_aNeg ^ w_bNeg;
                  r_negR  <= w_aNeg;
                  r_dz    <= op[1] && (b == '0);
                  r_cnt   <= '0;
                  r_acc   <= '0;
                  // multiply shifts the multiplier; divide shifts the dividend
                  r_mplr  <= op[1] ? w_magA : w_magB;
                  r_opnd  <= op[1] ? w_magB : w_magA;
                  r_state <= S_RUN;
               end
            end

            S_RUN: begin
               busy <= 1'b1;
               if (r_dz || (r_cnt == c_lastCnt)) begin
                  done     <= 1'b1;
                  div_zero <= r_dz;
                  if (!r_dz) begin
                     if (r_isDiv) begin
                        hi <= w_remRes;
                        lo <= w_quoRes;
                     end else begin
                        hi <= w_prodRes[2*WIDTH-1:WIDTH];
                        lo <= w_prodRes[WIDTH-1:0];
                     end
                  end
                  r_state <= S_FIN;
               end else begin
                  r_cnt <= r_cnt + c_cntOne;
                  if (r_isDiv) begin
                     r_acc  <= w_remNext;
                     r_mplr <= w_quoNext;
                  end else begin
                     r_acc  <= w_sum[WIDTH:1];
                     r_mplr <= {w_sum[0], r_mplr[WIDTH-1:1]};
                  end
               end
            end

            S_FIN: begin
               // start is not looked at here; a new request is taken only
               // once back in IDLE, the cycle after done
               busy     <= 1'b0;
               done     <= 1'b0;
               div_zero <= 1'b0;
               r_state  <= S_IDLE;
            end

            default: begin
               busy     <= 1'b0;
               done     <= 1'b0;
               div_zero <= 1'b0;
               r_state  <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
